// File: rtl/apb_capture_reader.sv
// APB read initiator: drains a slave capture buffer with a burst of single-beat
// reads and streams each returned word out on a valid/ready port.
module apb_capture_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_STEP  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [8:0]            cmd_count,
  input  logic                  cmd_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic [ADDR_WIDTH-1:0] apb_paddr,
  output logic                  apb_pwrite,
  output logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic [3:0]            apb_pstrb,
  output logic [2:0]            apb_pprot,
  input  logic [DATA_WIDTH-1:0] apb_prdata,
  input  logic                  apb_pready,
  input  logic                  apb_pslverr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_OUT    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0]            TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [8:0]            remaining;
  logic                  incr_q;
  logic [7:0]            tmo_cnt;

  // Stream handshake: a word transfers on any rising edge where rd_valid and
  // rd_ready are both high; rd_data/rd_last hold steady until that edge.

  always_ff @(posedge clk) begin
    if (rst_h) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (cmd_start) next_state = (cmd_count == 9'd0) ? S_DONE : S_SETUP;
      S_SETUP:  next_state = S_ACCESS;
      S_ACCESS: begin
        if (apb_pready)               next_state = apb_pslverr ? S_DONE : S_OUT;
        else if (tmo_cnt == TMO_LAST) next_state = S_DONE;
      end
      S_OUT:    if (rd_ready) next_state = (remaining == 9'd1) ? S_DONE : S_SETUP;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      addr_q    <= '0;
      remaining <= '0;
      incr_q    <= 1'b0;
      tmo_cnt   <= '0;
      rd_data   <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            addr_q    <= cmd_addr;
            remaining <= cmd_count;
            incr_q    <= cmd_incr;
            err       <= 1'b0;
            err_code  <= 2'b00;
          end
        end
        S_SETUP: tmo_cnt <= '0;
        S_ACCESS: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (apb_pready) begin
            if (apb_pslverr) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              rd_data <= apb_prdata;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
        S_OUT: begin
          if (rd_ready) begin
            remaining <= remaining - 9'd1;
            // Address wraps naturally at 2^ADDR_WIDTH.
            if (incr_q) addr_q <= addr_q + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    apb_psel    = (state == S_SETUP) || (state == S_ACCESS);
    apb_penable = (state == S_ACCESS);
    apb_paddr   = apb_psel ? addr_q : '0;
    apb_pwrite  = 1'b0;
    apb_pwdata  = '0;
    apb_pstrb   = 4'h0;
    apb_pprot   = 3'h0;
    rd_valid    = (state == S_OUT);
    rd_last     = (state == S_OUT) && (remaining == 9'd1);
    state_dbg   = state;
  end

endmodule
